// File: rtl/spi_rom_arbiter_pkg.sv
// Shared constants and state encoding for the SPI flash ROM arbiter.
// Imported by the top level and by the bit engine.
package spi_rom_arbiter_pkg;

    localparam logic [7:0]  SPI_CMD_READ = 8'h03;
    localparam int unsigned SPI_CMD_LEN  = 8;
    localparam int unsigned SPI_ADDR_LEN = 24;
    localparam int unsigned SPI_PRE_LEN  = SPI_CMD_LEN + SPI_ADDR_LEN;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4
    } arb_state_e;

    // True on the eighth bit of a byte, given the free-running 5-bit bit counter.
    function automatic logic last_bit_of_byte(input logic [4:0] cnt);
        return (cnt[2:0] == 3'd7);
    endfunction

endpackage

// File: rtl/spi_rom_arbiter_bit_engine.sv
// SPI bit engine: clk/2 SCLK phase toggle, 32-bit CMD+ADDR shifter, 8-bit receive
// shifter and a 5-bit bit counter that wraps after the preamble.
module spi_rom_arbiter_bit_engine
    import spi_rom_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic        en_i,
    input  logic [31:0] preamble_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        bit_end_o,
    output logic [4:0]  bit_cnt_o,
    output logic [7:0]  rx_byte_o
);

    logic        phase_q, phase_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  rx_q, rx_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;

    // Next-state: phase B ends each bit, shifting MOSI out and MISO in together.
    always_comb begin
        phase_d   = phase_q;
        sh_d      = sh_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        if (start_i) begin
            phase_d   = 1'b0;
            sh_d      = preamble_i;
            rx_d      = 8'h00;
            bit_cnt_d = 5'd0;
        end else if (en_i) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                sh_d      = {sh_q[30:0], 1'b0};
                rx_d      = {rx_q[6:0], miso_i};
                bit_cnt_d = bit_cnt_q + 5'd1;
            end else begin
                rx_d = rx_q;
            end
        end else begin
            phase_d = 1'b0;
        end
    end

    // Engine registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= 1'b0;
            sh_q      <= 32'h0000_0000;
            rx_q      <= 8'h00;
            bit_cnt_q <= 5'd0;
        end else begin
            phase_q   <= phase_d;
            sh_q      <= sh_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The shifter is empty after the preamble, so MOSI falls to 0 during DATA by itself.
    assign sclk_o    = en_i & phase_q;
    assign mosi_o    = en_i & sh_q[31];
    assign bit_end_o = en_i & phase_q;
    assign bit_cnt_o = bit_cnt_q;
    assign rx_byte_o = {rx_q[6:0], miso_i};

endmodule

// File: rtl/spi_rom_arbiter.sv
// Two-port SPI flash ROM read arbiter: port 0 has priority, bursts are non-preemptive,
// received bytes are tagged with the owning requester.
module spi_rom_arbiter
    import spi_rom_arbiter_pkg::*;
#(
    parameter logic [7:0]  READ_CMD = SPI_CMD_READ,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [23:0] addr0,
    input  logic [7:0]  len0,
    output logic        ack0,
    input  logic        req1,
    input  logic [23:0] addr1,
    input  logic [7:0]  len1,
    output logic        ack1,
    output logic        busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_id,
    output logic        done,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

    arb_state_e  state_q, state_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        id_q, id_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_id_q, rd_id_d;
    logic        done_q, done_d;

    logic        grant0_s, grant1_s, grant_s, cs_s;
    logic [31:0] preamble_s;
    logic        bit_end_s;
    logic [4:0]  bit_cnt_s;
    logic [7:0]  rx_byte_s;

    // Grant is decided in IDLE only; port 0 wins a same-cycle tie.
    assign grant0_s   = reset_n && (state_q == ST_IDLE) && req0;
    assign grant1_s   = reset_n && (state_q == ST_IDLE) && !req0 && req1;
    assign grant_s    = grant0_s | grant1_s;
    assign preamble_s = grant1_s ? {READ_CMD, addr1} : {READ_CMD, addr0};
    assign cs_s       = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);

    spi_rom_arbiter_bit_engine u_engine (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (grant_s),
        .en_i       (cs_s),
        .preamble_i (preamble_s),
        .miso_i     (spi_miso),
        .sclk_o     (spi_sclk),
        .mosi_o     (spi_mosi),
        .bit_end_o  (bit_end_s),
        .bit_cnt_o  (bit_cnt_s),
        .rx_byte_o  (rx_byte_s)
    );

    // Burst sequencing, byte countdown and read-data strobe generation.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        id_d       = id_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_id_d    = rd_id_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d    = ST_CMD;
                    id_d       = grant1_s;
                    byte_cnt_d = grant1_s ? len1 : len0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (bit_end_s && (bit_cnt_s == 5'(SPI_CMD_LEN - 1))) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_ADDR: begin
                if (bit_end_s && (bit_cnt_s == 5'(SPI_PRE_LEN - 1))) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bit_end_s && last_bit_of_byte(bit_cnt_s)) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rx_byte_s;
                    rd_id_d    = id_q;
                    if (byte_cnt_q == 8'd0) begin
                        done_d    = 1'b1;
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        byte_cnt_d = byte_cnt_q - 8'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; an asynchronous reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 8'd0;
            gap_cnt_q  <= 8'd0;
            id_q       <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            id_q       <= id_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            done_q     <= done_d;
        end
    end

    assign ack0     = grant0_s;
    assign ack1     = grant1_s;
    assign busy     = (state_q != ST_IDLE) || grant_s;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign done     = done_q;
    assign spi_cs   = cs_s;

endmodule

// File: tb/tb_spi_rom_arbiter.sv
// Scoreboard bench for spi_rom_arbiter: a wire-level ROM model answers bursts, expected
// bytes and burst shapes are queued at issue time and checked by a separate monitor.
module tb_spi_rom_arbiter;

    localparam int CS_GAP = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [23:0] addr0 = 24'h0, addr1 = 24'h0;
    logic [7:0]  len0 = 8'h0, len1 = 8'h0;
    logic        ack0, ack1, busy, rd_valid, rd_id, done;
    logic        spi_cs, spi_sclk, spi_mosi;
    logic        spi_miso;
    logic [7:0]  rd_data;

    spi_rom_arbiter #(.READ_CMD(8'h03), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .addr0(addr0), .len0(len0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .len1(len1), .ack1(ack1),
        .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id), .done(done),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    typedef struct { logic id; logic [7:0] data; logic last; } byte_t;
    typedef struct { logic id; int len; } burst_t;

    byte_t       exp_q[$];
    burst_t      burst_q[$];
    logic [31:0] hdr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cs_fall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        if (a == 24'h00A000) return 8'hA5;
        else if (a == 24'h00A001) return 8'h3C;
        else return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: a burst returns ROM[addr+i] for i in 0..len, in issue order.
    task automatic expect_burst(input logic id, input logic [23:0] a, input int len, input bit with_data);
        byte_t  b;
        burst_t bb;
        bb.id = id;
        bb.len = len;
        burst_q.push_back(bb);
        if (with_data) begin
            hdr_q.push_back({8'h03, a});
            for (int i = 0; i <= len; i++) begin
                b.id = id;
                b.data = rom_byte(a + 24'(i));
                b.last = (i == len);
                exp_q.push_back(b);
            end
        end
    endtask

    // ROM: captures CMD+ADDR on rising SCLK, presents data bits during phase A.
    int          rbit = 0;
    logic [31:0] rhdr = 32'h0;
    always @(negedge clk) begin
        int          d;
        logic [7:0]  rb;
        logic [31:0] hnew, hexp;
        if (!spi_cs) begin
            rbit = 0;
            spi_miso = 1'b0;
        end else if (!spi_sclk) begin
            if (rbit >= 32) begin
                d = rbit - 32;
                rb = rom_byte(rhdr[23:0] + 24'(d / 8));
                spi_miso = rb[3'(7 - (d % 8))];
                chk("mosi_data_low", 32'(spi_mosi), 32'd0);
            end
        end else begin
            if (rbit < 32) begin
                hnew = {rhdr[30:0], spi_mosi};
                rhdr = hnew;
                if (rbit == 31) begin
                    if (hdr_q.size() == 0) fail_now("unexpected_header");
                    else begin
                        hexp = hdr_q.pop_front();
                        chk("mosi_header", hnew, hexp);
                    end
                end
            end
            rbit++;
        end
    end

    // Monitor: grants, SPI framing, gap and read strobes against the queued expectations.
    int   ack_at = 0;
    bit   want_first = 0;
    int   cs_run = 0;
    int   cur_len = 0;
    int   gap_left = 0;
    logic cs_prev = 1'b0;
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        burst_t b;
        byte_t  e;
        if (!reset_n) begin
            cs_run = 0; cs_prev = 1'b0; gap_left = 0; want_first = 0; ack_prev = 1'b0;
        end else begin
            if (ack0 || ack1) begin
                chk("ack_one_hot", 32'(ack0 & ack1), 32'd0);
                chk("ack_single_cycle", 32'(ack_prev), 32'd0);
                chk("ack_busy", 32'(busy), 32'd1);
                chk("ack_cs_low", 32'(spi_cs), 32'd0);
                if (burst_q.size() == 0) fail_now("unexpected_ack");
                else begin
                    b = burst_q.pop_front();
                    chk("ack_port", 32'(ack1), 32'(b.id));
                    cur_len = b.len;
                    ack_at = cyc;
                    want_first = 1;
                end
            end
            if (spi_cs) begin
                chk("sclk_phase", 32'(spi_sclk), 32'(cs_run % 2));
                cs_run++;
            end else begin
                chk("sclk_idle_low", 32'(spi_sclk), 32'd0);
                chk("mosi_idle_low", 32'(spi_mosi), 32'd0);
                if (cs_prev) begin
                    chk("cs_high_len", 32'(cs_run), 32'(2 * (32 + 8 * (cur_len + 1))));
                    cs_run = 0;
                    gap_left = CS_GAP;
                    last_cs_fall = cyc;
                end
                if (gap_left > 0) begin
                    chk("gap_busy", 32'(busy), 32'd1);
                    chk("gap_no_ack", 32'(ack0 | ack1), 32'd0);
                    gap_left--;
                end
            end
            if (rd_valid) begin
                if (exp_q.size() == 0) fail_now("unexpected_rd_valid");
                else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e.data));
                    chk("rd_id", 32'(rd_id), 32'(e.id));
                    chk("done", 32'(done), 32'(e.last));
                end
                if (want_first) begin
                    chk("first_latency", 32'(cyc - ack_at), 32'd81);
                    want_first = 0;
                end
            end else if (done) begin
                fail_now("done_without_valid");
            end
            cs_prev = spi_cs;
            ack_prev = ack0 | ack1;
        end
    end

    task automatic wait_ack(input logic port, output int at);
        int n;
        n = 0;
        at = -1;
        while (n < 6000 && at < 0) begin
            @(negedge clk);
            if ((port ? ack1 : ack0) === 1'b1) at = cyc;
            n++;
        end
        if (at < 0) fail_now(port ? "ack1_timeout" : "ack0_timeout");
        @(posedge clk); #1;
        if (port) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 6000 && !(exp_q.size() == 0 && busy === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) fail_now("drain_timeout");
    endtask

    task automatic drive_req(input logic port, input logic [23:0] a, input int l);
        if (port) begin addr1 = a; len1 = 8'(l); req1 = 1'b1; end
        else begin addr0 = a; len0 = 8'(l); req0 = 1'b1; end
    endtask

    task automatic run_single(input logic port, input logic [23:0] a, input int l);
        int at, issue;
        @(posedge clk); #1;
        issue = cyc;
        drive_req(port, a, l);
        expect_burst(port, a, l, 1'b1);
        wait_ack(port, at);
        chk("grant_when_idle", 32'(at), 32'(issue));
        drain();
    endtask

    task automatic run_both(input logic [23:0] a0, input int l0, input logic [23:0] a1, input int l1);
        int at0, at1;
        @(posedge clk); #1;
        drive_req(1'b0, a0, l0);
        drive_req(1'b1, a1, l1);
        expect_burst(1'b0, a0, l0, 1'b1);
        expect_burst(1'b1, a1, l1, 1'b1);
        wait_ack(1'b0, at0);
        wait_ack(1'b1, at1);
        chk("ack1_after_gap", 32'(at1), 32'(last_cs_fall + CS_GAP));
        drain();
    endtask

    task automatic run_stagger(input logic [23:0] a1, input int l1, input logic [23:0] a0, input int l0, input int dly);
        int at0, at1;
        @(posedge clk); #1;
        drive_req(1'b1, a1, l1);
        expect_burst(1'b1, a1, l1, 1'b1);
        wait_ack(1'b1, at1);
        repeat (dly) @(posedge clk);
        #1;
        drive_req(1'b0, a0, l0);
        expect_burst(1'b0, a0, l0, 1'b1);
        wait_ack(1'b0, at0);
        chk("ack0_after_gap", 32'(at0), 32'(last_cs_fall + CS_GAP));
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_outputs", 32'({ack0, ack1, busy, rd_valid, rd_id, done, spi_cs, spi_sclk, spi_mosi}), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        run_single(1'b0, 24'h000140, 0);
        run_both(24'h012345, 1, 24'h0ABCDE, 2);
        run_stagger(24'h200000, 3, 24'h300010, 0, 60);
        run_single(1'b0, 24'h00A000, 1);

        // Reset in the middle of the ADDR phase: burst dropped, no data, no done.
        @(posedge clk); #1;
        drive_req(1'b0, 24'h055500, 2);
        expect_burst(1'b0, 24'h055500, 2, 1'b0);
        wait_ack(1'b0, at);
        repeat (25) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_cs", 32'(spi_cs), 32'd0);
        chk("rst_mid_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (150) @(posedge clk);
        run_single(1'b0, 24'h055500, 2);

        run_single(1'b0, 24'($urandom), 255);

        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0: run_single(1'($urandom_range(0, 1)), 24'($urandom), int'($urandom_range(0, 5)));
                1: run_both(24'($urandom), int'($urandom_range(0, 4)), 24'($urandom), int'($urandom_range(0, 4)));
                default: run_stagger(24'($urandom), int'($urandom_range(1, 4)), 24'($urandom),
                                     int'($urandom_range(0, 4)), int'($urandom_range(1, 60)));
            endcase
        end

        repeat (10) @(posedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("burst_q_empty", 32'(burst_q.size()), 32'd0);
        chk("hdr_q_empty", 32'(hdr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
